// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: exponent width, denormal exponent limits,
// normalizer FSM states and the rounding-mode type shared with sigrnd.
package fpu_pkg;

  localparam int unsigned EW  = 13;  // signed exponent width
  localparam int unsigned F1W = 55;  // rounder input word width

  // Smallest normal exponents for double / single precision
  localparam logic signed [EW-1:0] EMIN_DB = EW'(-1022);
  localparam logic signed [EW-1:0] EMIN_SG = EW'(-126);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sig_norm_state_t;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_t;

endpackage

// File: rtl/sig_norm_if.sv
// Operand/result handshake bundle between the datapath, sig_norm and sigrnd.
//   in_valid/in_ready  : operand handshake (s_in, db_in, RM_in, e_in, fr_in)
//   out_valid/out_ready: result handshake (s, db, RM, e_out, f1, zero)
// master = producer of operands / consumer of results; slave = sig_norm.
interface sig_norm_if
  import fpu_pkg::*;
#(
  parameter int unsigned W = 108
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 s_in;
  logic                 db_in;
  rm_t                  RM_in;
  logic signed [EW-1:0] e_in;
  logic [W-1:0]         fr_in;

  logic                 out_valid;
  logic                 out_ready;
  logic                 s;
  logic                 db;
  rm_t                  RM;
  logic signed [EW-1:0] e_out;
  logic [F1W-1:0]       f1;
  logic                 zero;

  modport master (
    output in_valid, s_in, db_in, RM_in, e_in, fr_in, out_ready,
    input  in_ready, out_valid, s, db, RM, e_out, f1, zero
  );

  modport slave (
    input  in_valid, s_in, db_in, RM_in, e_in, fr_in, out_ready,
    output in_ready, out_valid, s, db, RM, e_out, f1, zero
  );

endinterface

// File: rtl/sig_norm_step.sv
// Purely combinational single normalization step.
//   fr_i/e_i/st_i       : current significand, exponent, sticky
//   clamp_en_i, emin_i  : stop left shifts at emin_i when clamp_en_i is set
//   fr_c_o/e_c_o/st_c_o : next significand, exponent, sticky
//   done_c_o            : no further step needed (inputs passed through)
module sig_norm_step
  import fpu_pkg::*;
#(
  parameter int unsigned W   = 108,
  parameter int unsigned CSH = 16
) (
  input  logic [W-1:0]         fr_i,
  input  logic signed [EW-1:0] e_i,
  input  logic                 st_i,
  input  logic                 clamp_en_i,
  input  logic signed [EW-1:0] emin_i,
  output logic [W-1:0]         fr_c_o,
  output logic signed [EW-1:0] e_c_o,
  output logic                 st_c_o,
  output logic                 done_c_o
);

  localparam int unsigned XW = EW + 1;

  logic signed [XW-1:0] e_x;
  logic signed [XW-1:0] emin_x;
  logic signed [XW-1:0] e_coarse_x;
  logic                 at_min;
  logic                 coarse_ok;

  // One extra bit keeps the post-coarse-shift exponent compare from wrapping
  always_comb begin
    e_x        = {e_i[EW-1], e_i};
    emin_x     = {emin_i[EW-1], emin_i};
    e_coarse_x = e_x - XW'(CSH);
    at_min     = clamp_en_i && (e_x <= emin_x);
    coarse_ok  = (fr_i[W-2 -: CSH] == '0) &&
                 !(clamp_en_i && (e_coarse_x < emin_x));
  end

  // Priority: overflow right shift, clamp stop, coarse left, fine left, done
  always_comb begin
    fr_c_o   = fr_i;
    e_c_o    = e_i;
    st_c_o   = st_i;
    done_c_o = 1'b0;
    if (fr_i[W-1]) begin
      fr_c_o = fr_i >> 1;
      st_c_o = st_i | fr_i[0];
      e_c_o  = e_i + EW'(1);
    end else if (at_min) begin
      done_c_o = 1'b1;
    end else if (coarse_ok) begin
      fr_c_o = fr_i << CSH;
      e_c_o  = e_i - EW'(CSH);
    end else if (!fr_i[W-2]) begin
      fr_c_o = fr_i << 1;
      e_c_o  = e_i - EW'(1);
    end else begin
      done_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/sig_norm.sv
// Multi-cycle significand normalizer feeding sigrnd.
// Moves the leading one of a raw W-bit significand (range [0,4)) to the
// hidden-bit position, adjusts the signed exponent and folds discarded bits
// into sticky, then presents the 55-bit f1 word over a valid/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sig_norm_if.slave (operand in, result out)
// Build option: SIG_NORM_DENORM_CLAMP_EN stops left shifts at EMIN and
// emits a denormal f1 instead of fully normalizing.
module sig_norm
  import fpu_pkg::*;
#(
  parameter int unsigned W   = 108,
  parameter int unsigned CSH = 16
) (
  input logic       clk,
  input logic       rst_n,
  sig_norm_if.slave bus
);

  sig_norm_state_t      state_q, state_d;
  logic [W-1:0]         fr_q, fr_d;
  logic signed [EW-1:0] e_q, e_d;
  logic                 st_q, st_d;
  logic                 s_q, s_d;
  logic                 db_q, db_d;
  rm_t                  rm_q, rm_d;
  logic                 zero_q, zero_d;
  logic [F1W-1:0]       f1_q, f1_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [W-1:0]         step_fr;
  logic signed [EW-1:0] step_e;
  logic                 step_st;
  logic                 step_done;
  logic                 clamp_en;
  logic signed [EW-1:0] emin;

`ifdef SIG_NORM_DENORM_CLAMP_EN
  assign clamp_en = 1'b1;
`else
  assign clamp_en = 1'b0;
`endif

  assign emin = db_q ? EMIN_DB : EMIN_SG;

  sig_norm_step #(
    .W   (W),
    .CSH (CSH)
  ) u_step (
    .fr_i       (fr_q),
    .e_i        (e_q),
    .st_i       (st_q),
    .clamp_en_i (clamp_en),
    .emin_i     (emin),
    .fr_c_o     (step_fr),
    .e_c_o      (step_e),
    .st_c_o     (step_st),
    .done_c_o   (step_done)
  );

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    fr_d    = fr_q;
    e_d     = e_q;
    st_d    = st_q;
    s_d     = s_q;
    db_d    = db_q;
    rm_d    = rm_q;
    zero_d  = zero_q;
    f1_d    = f1_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          fr_d = bus.fr_in;
          e_d  = bus.e_in;
          s_d  = bus.s_in;
          db_d = bus.db_in;
          rm_d = bus.RM_in;
          st_d = 1'b0;
          if (bus.fr_in == '0) begin
            zero_d  = 1'b1;
            f1_d    = '0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        fr_d = step_fr;
        e_d  = step_e;
        st_d = step_st;
        if (step_done) begin
          // Step passes fr/st through unchanged when done
          f1_d    = {fr_q[W-2 -: F1W-1], (|fr_q[W-F1W-1:0]) | st_q};
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          zero_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fr_q        <= '0;
      e_q         <= '0;
      st_q        <= 1'b0;
      s_q         <= 1'b0;
      db_q        <= 1'b0;
      rm_q        <= RM_RNE;
      zero_q      <= 1'b0;
      f1_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fr_q        <= fr_d;
      e_q         <= e_d;
      st_q        <= st_d;
      s_q         <= s_d;
      db_q        <= db_d;
      rm_q        <= rm_d;
      zero_q      <= zero_d;
      f1_q        <= f1_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.db        = db_q;
  assign bus.RM        = rm_q;
  assign bus.e_out     = e_q;
  assign bus.f1        = f1_q;
  assign bus.zero      = zero_q;

endmodule
